// File: rtl/booth_ctrl_pkg.sv
// Shared types for the Booth multiplier sequencer: state encodings, Booth pair codes, control word.
// No logic of its own; helpers are pure combinational functions.
// Control word fields map one-to-one onto the datapath enables.
package booth_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_M = 4'd1,
        ST_LOAD_Q = 4'd2,
        ST_EVAL   = 4'd3,
        ST_ADD    = 4'd4,
        ST_SUB    = 4'd5,
        ST_NOP    = 4'd6,
        ST_SHIFT  = 4'd7,
        ST_OUT_A  = 4'd8,
        ST_OUT_Q  = 4'd9,
        ST_DONE   = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    typedef struct packed {
        logic load_m;
        logic load_q;
        logic clear_a;
        logic load_a;
        logic add_sub;
        logic shift_en;
        logic out_a;
        logic out_q;
        logic busy;
        logic done;
    } ctrl_t;

    // Booth recoding of the {Q[0], Q[-1]} pair
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        booth_op_t op;
        op = BOOTH_NOP;
        case ({q0, q_m1})
            2'b10:   op = BOOTH_SUB;
            2'b01:   op = BOOTH_ADD;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

    // Next-state rule; last_iter is the counter's pre-increment terminal flag
    function automatic state_t fsm_next(input state_t st, input logic start,
                                        input logic q0, input logic q_m1,
                                        input logic last_iter);
        state_t nxt;
        nxt = ST_IDLE;
        case (st)
            ST_IDLE:   nxt = start ? ST_LOAD_M : ST_IDLE;
            ST_LOAD_M: nxt = ST_LOAD_Q;
            ST_LOAD_Q: nxt = ST_EVAL;
            ST_EVAL: begin
                case (booth_decode(q0, q_m1))
                    BOOTH_SUB: nxt = ST_SUB;
                    BOOTH_ADD: nxt = ST_ADD;
                    default:   nxt = ST_NOP;
                endcase
            end
            ST_ADD, ST_SUB, ST_NOP: nxt = ST_SHIFT;
            ST_SHIFT:  nxt = last_iter ? ST_OUT_A : ST_EVAL;
            ST_OUT_A:  nxt = ST_OUT_Q;
            ST_OUT_Q:  nxt = ST_DONE;
            default:   nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Moore output decode: every enable is a pure function of the state
    function automatic ctrl_t ctrl_decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_LOAD_M: begin c.load_m = 1'b1; c.busy = 1'b1; end
            ST_LOAD_Q: begin c.load_q = 1'b1; c.clear_a = 1'b1; c.busy = 1'b1; end
            ST_EVAL:   c.busy = 1'b1;
            ST_ADD:    begin c.load_a = 1'b1; c.busy = 1'b1; end
            ST_SUB:    begin c.load_a = 1'b1; c.add_sub = 1'b1; c.busy = 1'b1; end
            ST_NOP:    c.busy = 1'b1;
            ST_SHIFT:  begin c.shift_en = 1'b1; c.busy = 1'b1; end
            ST_OUT_A:  begin c.out_a = 1'b1; c.busy = 1'b1; end
            ST_OUT_Q:  begin c.out_q = 1'b1; c.busy = 1'b1; end
            ST_DONE:   c.done = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/booth_ctrl_if.sv
// Bundle between the Booth sequencer and its requester/datapath.
// Pure wiring, no latency.
// No flow control: start is a level request, busy tells the requester when it is ignored.
interface booth_ctrl_if;
    logic start;
    logic q0;
    logic q_m1;
    logic load_m;
    logic load_q;
    logic clear_a;
    logic load_a;
    logic add_sub;
    logic shift_en;
    logic out_a;
    logic out_q;
    logic busy;
    logic done;

    modport master (
        output start, q0, q_m1,
        input  load_m, load_q, clear_a, load_a, add_sub, shift_en, out_a, out_q, busy, done
    );

    modport slave (
        input  start, q0, q_m1,
        output load_m, load_q, clear_a, load_a, add_sub, shift_en, out_a, out_q, busy, done
    );
endinterface

// File: rtl/booth_ctrl_iter_cnt.sv
// Iteration counter for multi-cycle ALU sequencers; term flags the final iteration.
// term is combinational from the count register (visible the cycle the count reaches width-1).
// No backpressure: clear has priority over increment.
module booth_ctrl_iter_cnt #(
    parameter int width = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic term
);
    localparam int CW = $clog2(width);

    logic [CW-1:0] cnt;

    // Count iterations; cleared at operand load so a stale count never leaks into a new op
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CW'(width - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer driving the A/Q/M register enables and outbus selects.
// Fixed 3*width+5 cycles from start sampled to done; enables are registered Moore outputs.
// No backpressure: start is honoured only in IDLE; requests while busy or done are dropped.
module booth_ctrl #(
    parameter int width = 8
) (
    input  logic         clk,
    input  logic         reset,
    booth_ctrl_if.slave  bus
);
    import booth_ctrl_pkg::*;

    state_t state;
    ctrl_t  ctrl_q;
    logic   last_iter;

    // Shared counter: cleared while Q is loaded, advanced once per shift
    booth_ctrl_iter_cnt #(.width(width)) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_LOAD_Q),
        .inc   (state == ST_SHIFT),
        .term  (last_iter)
    );

    // Sequencer: next state and its decoded enables are registered together,
    // so every output is glitch-free and depends on the state alone
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ctrl_q <= '0;
        end else begin
            state  <= fsm_next(state, bus.start, bus.q0, bus.q_m1, last_iter);
            ctrl_q <= ctrl_decode(fsm_next(state, bus.start, bus.q0, bus.q_m1, last_iter));
        end
    end

    assign bus.load_m   = ctrl_q.load_m;
    assign bus.load_q   = ctrl_q.load_q;
    assign bus.clear_a  = ctrl_q.clear_a;
    assign bus.load_a   = ctrl_q.load_a;
    assign bus.add_sub  = ctrl_q.add_sub;
    assign bus.shift_en = ctrl_q.shift_en;
    assign bus.out_a    = ctrl_q.out_a;
    assign bus.out_q    = ctrl_q.out_q;
    assign bus.busy     = ctrl_q.busy;
    assign bus.done     = ctrl_q.done;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: behavioural A/Q/M datapath, cycle-schedule model and product scoreboard.
module tb_booth_ctrl;
    localparam int W        = 8;
    localparam int IW       = $clog2(W);
    localparam int PW       = 2 * W;
    localparam int LAT_DONE = 3 * W + 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    booth_ctrl_if bus();

    booth_ctrl #(.width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus-owned model state
    int             act_k   = -1000;
    int             kill_at = -1000;
    bit             dp_mode = 1'b1;
    logic [W-1:0]   op_m    = '0;
    logic [W-1:0]   op_q    = '0;
    logic [1:0]     pat [W];
    bit             mon_on  = 1'b0;
    bit             end_req = 1'b0;

    // behavioural datapath, A carries a guard bit so M = -2^(W-1) multiplies correctly
    logic [W:0]   a_r;
    logic [W-1:0] q_r, m_r;
    logic         qm1_r;
    int           nshift = 0;
    logic [W-1:0] inbus, outbus;
    logic [1:0]   noise = 2'b00;
    logic [1:0]   qdrv;

    assign inbus  = bus.load_m ? op_m : op_q;
    assign outbus = bus.out_a ? a_r[W-1:0] : (bus.out_q ? q_r : '0);

    always @(posedge clk) begin
        if (bus.load_m) m_r <= inbus;
        if (bus.load_q) q_r <= inbus;
        if (bus.clear_a) begin
            a_r   <= '0;
            qm1_r <= 1'b0;
        end
        if (bus.load_a)
            a_r <= bus.add_sub ? a_r - {m_r[W-1], m_r} : a_r + {m_r[W-1], m_r};
        if (bus.shift_en)
            {a_r, q_r, qm1_r} <= {a_r[W], a_r, q_r};
        if (bus.load_q) nshift <= 0;
        else if (bus.shift_en) nshift <= nshift + 1;
        noise <= 2'($urandom);
    end

    // q0/q_m1 come from the datapath, or in forced mode from the pattern during
    // the evaluation cycle of each iteration and random junk otherwise
    always_comb begin
        int rel;
        rel  = cyc - act_k;
        qdrv = {q_r[0], qm1_r};
        if (!dp_mode) begin
            qdrv = noise;
            if (rel >= 3 && rel <= 3 * W + 2 && (rel - 3) % 3 == 0 &&
                !(kill_at > act_k && cyc >= kill_at))
                qdrv = pat[IW'((rel - 3) / 3)];
        end
    end
    assign bus.q0   = qdrv[1];
    assign bus.q_m1 = qdrv[0];

    function automatic bit model_active(int c);
        int rel;
        rel = c - act_k;
        if (rel < 0 || rel > LAT_DONE) return 1'b0;
        if (kill_at > act_k && c >= kill_at) return 1'b0;
        return 1'b1;
    endfunction

    // expected outputs at cycle rel after the start-sampling edge
    // bits: 9 load_m 8 load_q 7 clear_a 6 load_a 5 add_sub 4 shift_en 3 out_a 2 out_q 1 busy 0 done
    function automatic logic [9:0] exp_vec(int rel);
        logic [9:0] v;
        int it, ph;
        v = '0;
        if (rel >= 1 && rel <= 3 * W + 4) v[1] = 1'b1;
        if (rel == 1) v[9] = 1'b1;
        else if (rel == 2) v[8:7] = 2'b11;
        else if (rel >= 3 && rel <= 3 * W + 2) begin
            it = (rel - 3) / 3;
            ph = (rel - 3) % 3;
            if (ph == 1) begin
                if (pat[IW'(it)] == 2'b10) v[6:5] = 2'b11;
                else if (pat[IW'(it)] == 2'b01) v[6:5] = 2'b10;
            end else if (ph == 2) v[4] = 1'b1;
        end
        else if (rel == 3 * W + 3) v[3] = 1'b1;
        else if (rel == 3 * W + 4) v[2] = 1'b1;
        else if (rel == 3 * W + 5) v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] ref_product(logic [W-1:0] m, logic [W-1:0] q);
        logic signed [PW-1:0] p;
        p = PW'($signed(m)) * PW'($signed(q));
        return p;
    endfunction

    // scoreboard / monitor
    int             checks   = 0;
    int             failures = 0;
    logic [W-1:0]   hi_cap   = '0;
    logic [PW-1:0]  exp_prod_q[$];
    int             exp_done_q[$];
    bit             op_dp    = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d got=unexpected exp=none", name, cyc);
    endtask

    always @(negedge clk) begin
        logic [9:0] got, exp, mask;
        if (mon_on) begin
            if (cyc == act_k) begin
                exp_done_q.push_back(act_k + LAT_DONE);
                op_dp = dp_mode;
                if (dp_mode) exp_prod_q.push_back(ref_product(op_m, op_q));
            end
            if (cyc == kill_at && kill_at > act_k) begin
                if (exp_done_q.size() > 0) void'(exp_done_q.pop_back());
                if (op_dp && exp_prod_q.size() > 0) void'(exp_prod_q.pop_back());
            end
            got  = {bus.load_m, bus.load_q, bus.clear_a, bus.load_a, bus.add_sub,
                    bus.shift_en, bus.out_a, bus.out_q, bus.busy, bus.done};
            exp  = model_active(cyc) ? exp_vec(cyc - act_k) : '0;
            mask = exp[6] ? 10'h3FF : 10'h3DF;
            check("ctrl_vec", 32'(got & mask), 32'(exp & mask));

            if (bus.out_a === 1'b1) hi_cap = outbus;
            if (bus.out_q === 1'b1 && op_dp) begin
                if (exp_prod_q.size() == 0) fail_now("product_extra");
                else check("product", 32'({hi_cap, outbus}), 32'(exp_prod_q.pop_front()));
            end
            if (bus.done === 1'b1) begin
                if (exp_done_q.size() == 0) fail_now("done_extra");
                else check("done_cycle", cyc, exp_done_q.pop_front());
                check("shift_count", nshift, W);
            end
            if (end_req) begin
                check("done_q_empty", exp_done_q.size(), 0);
                check("prod_q_empty", exp_prod_q.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit dp, input logic [W-1:0] m, input logic [W-1:0] q);
        logic prev;
        op_m    = m;
        op_q    = q;
        dp_mode = dp;
        if (dp) begin
            prev = 1'b0;
            for (int i = 0; i < W; i++) begin
                pat[i] = {q[i], prev};
                prev   = q[i];
            end
        end
        act_k     = cyc;
        bus.start = 1'b1;
    endtask

    task automatic run_op(input bit dp, input logic [W-1:0] m, input logic [W-1:0] q,
                          input int ign_rel, input int kill_rel, input bit chain);
        issue(dp, m, q);
        for (int r = 1; r <= LAT_DONE + 1; r++) begin
            tick();
            bus.start = (r == ign_rel) || (chain && r == LAT_DONE + 1);
            if (r == kill_rel) begin
                reset   = 1'b1;
                kill_at = cyc + 1;
                tick();
                reset     = 1'b0;
                bus.start = 1'b0;
                tick();
                return;
            end
        end
    endtask

    initial begin
        bit   dp, ch;
        int   ign, kil;
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) pat[i] = 2'b00;

        // reset held two cycles, then idle with start low
        reset = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();

        // Booth pairs all 00: shifts only
        run_op(1'b0, 8'h5A, 8'h3C, 0, 0, 1'b0);
        tick();

        // SUB, ADD, NOP then mixed
        pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b00; pat[3] = 2'b11;
        pat[4] = 2'b10; pat[5] = 2'b11; pat[6] = 2'b01; pat[7] = 2'b00;
        run_op(1'b0, 8'h00, 8'h00, 0, 0, 1'b0);

        // start during iteration 4 is ignored
        run_op(1'b1, 8'h05, 8'h07, 12, 0, 1'b0);

        // reset in SHIFT of iteration 3, then a full run
        run_op(1'b1, 8'h11, 8'h22, 0, 11, 1'b0);
        run_op(1'b1, 8'h7F, 8'h81, 0, 0, 1'b0);

        // datapath products, start held high across both
        run_op(1'b1, 8'h03, 8'hFE, 0, 0, 1'b1);
        run_op(1'b1, 8'h80, 8'h80, 29, 0, 1'b0);
        tick();

        // randomized mix
        for (int n = 0; n < 24; n++) begin
            dp  = ($urandom_range(0, 9) < 7);
            if (!dp) for (int i = 0; i < W; i++) pat[i] = 2'($urandom);
            ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 29)) : 0;
            kil = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 26)) : 0;
            ch  = ($urandom_range(0, 3) == 0) && (kil == 0);
            run_op(dp, W'($urandom), W'($urandom), ign, kil, ch);
            if (!ch) repeat ($urandom_range(0, 2)) tick();
        end
        bus.start = 1'b0;
        repeat (3) tick();
        end_req = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL summary_not_reached cyc=%0d", cyc);
        $fatal(1, "bench did not reach summary");
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
